// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with fill count, almost-full/empty thresholds,
// sticky overflow/underflow flags and an optional first-word-fall-through read port.
module sync_fifo_param #(
    parameter int DWIDTH    = 8,
    parameter int DEPTH     = 16,
    parameter int AFULL_TH  = 12,
    parameter int AEMPTY_TH = 4,
    parameter int FWFT      = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr,
    input  logic [DWIDTH-1:0]          din,
    input  logic                       rd,
    output logic [DWIDTH-1:0]          dout,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic                       underflow,
    input  logic                       clr_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DWIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wptr;
    logic [AW-1:0]     r_rptr;
    logic [CW-1:0]     r_count;
    logic              r_overflow;
    logic              r_underflow;
    logic              w_wr_ok;
    logic              w_rd_ok;

    // Handshake: wr/rd are requests; a request is accepted in the cycle it is
    // asserted when w_wr_ok/w_rd_ok is high, otherwise it is dropped and flagged.
    // A read on a full FIFO frees the slot the concurrent write needs.
    assign w_rd_ok = rd && !empty;
    assign w_wr_ok = wr && (!full || w_rd_ok);

    assign count        = r_count;
    assign full         = (r_count == CW'(DEPTH));
    assign empty        = (r_count == '0);
    assign almost_full  = (r_count >= CW'(AFULL_TH));
    assign almost_empty = (r_count <= CW'(AEMPTY_TH));
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

    always_ff @(posedge clk) begin
        if (w_wr_ok && !rst) begin
            r_mem[r_wptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_wr_ok) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_rd_ok) begin
                r_rptr <= r_rptr + 1'b1;
            end
            if (w_wr_ok && !w_rd_ok) begin
                r_count <= r_count + 1'b1;
            end else if (w_rd_ok && !w_wr_ok) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    // A new error in the same cycle as clr_err keeps the flag set.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (wr && !w_wr_ok) begin
                r_overflow <= 1'b1;
            end else if (clr_err) begin
                r_overflow <= 1'b0;
            end
            if (rd && !w_rd_ok) begin
                r_underflow <= 1'b1;
            end else if (clr_err) begin
                r_underflow <= 1'b0;
            end
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign dout = empty ? '0 : r_mem[r_rptr];
        end else begin : g_std
            logic [DWIDTH-1:0] r_dout;
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_dout <= '0;
                end else if (w_rd_ok) begin
                    r_dout <= r_mem[r_rptr];
                end
            end
            assign dout = r_dout;
        end
    endgenerate

endmodule

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
Parametrised single-clock FIFO, successor to the team's fixed 8x16 FIFO.
- Width, depth and almost-full/almost-empty thresholds are configurable.
- Supports true simultaneous read/write and an optional first-word-fall-through (FWFT) read mode.
- Exposes a fill count and sticky overflow/underflow error flags.
- Sits between stream producers/consumers in the verification and datapath environments.

Parameters:
- DWIDTH, 8, data width in bits (>=1).
- DEPTH, 16, number of entries; power of two, >=2.
- AFULL_TH, 12, almost_full asserts when count >= AFULL_TH (1..DEPTH).
- AEMPTY_TH, 4, almost_empty asserts when count <= AEMPTY_TH (0..DEPTH-1).
- FWFT, 0, 0 = standard registered read; 1 = first-word-fall-through.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- wr  in  1  write request.
- din  in  DWIDTH  write data.
- rd  in  1  read request.
- dout  out  DWIDTH  read data.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count >= AFULL_TH.
- almost_empty  out  1  count <= AEMPTY_TH.
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- overflow  out  1  sticky: a write was rejected.
- underflow  out  1  sticky: a read was rejected.
- clr_err  in  1  synchronous clear of overflow/underflow.

Behaviour:
- Reset (rst=1 at a clock edge) overrides all other inputs. After reset: wptr=0, rptr=0, count=0, dout=0, overflow=0, underflow=0, empty=1, full=0, almost_empty=1, almost_full=0 (for AFULL_TH>0). Memory contents are not cleared.
- Pointers are $clog2(DEPTH) bits wide and wrap naturally from DEPTH-1 to 0. count is a separate (log2+1)-bit register. All status flags are combinational decodes of count.
- Write acceptance: wr_ok = wr && (!full || rd_ok). When accepted, mem[wptr]<=din and wptr increments.
- Read acceptance: rd_ok = rd && !empty. When accepted, rptr increments.
- Count update:
  - +1 when only a write is accepted.
  - -1 when only a read is accepted.
  - unchanged when both are accepted, or neither.
- Full with rd&&wr: both are accepted and count stays at DEPTH. The read frees a slot in the same cycle.
- Empty with rd&&wr: the write is accepted, the read is rejected, count becomes 1, and underflow sets.
- Rejected write (wr && !wr_ok) sets overflow. Rejected read (rd && !rd_ok) sets underflow. Both flags stay set until rst, or until clr_err=1 at an edge.
- If clr_err coincides with a new error, the set wins and the flag stays 1.
- FWFT=0:
  - On an accepted read, dout <= mem[rptr], visible the cycle after the request (latency 1).
  - dout holds its value on all other cycles.
- FWFT=1:
  - dout = mem[rptr] combinationally whenever !empty; dout = 0 when empty.
  - A word written into an empty FIFO appears on dout in the cycle after the write edge, together with empty deasserting.
  - An accepted rd advances to the next word at the next edge.
- No illegal states. Reset asserted mid-burst discards all contents in that cycle.

Test Plan:
- Reset, then 16 writes of 0x00..0x0F (defaults), then 16 reads -> data returns in order 0x00..0x0F, 1 cycle after each rd. full=1 only at count=16; empty=1 at the end; no error flags.
- Fill to 16, then assert wr (din=0xAA) alone -> overflow=1, count stays 16, 0xAA never read out. Pulse clr_err -> overflow=0.
- From empty, assert rd&&wr with din=0x55 -> count=1, underflow=1, next read returns 0x55.
- Fill to 16, then 20 cycles of rd&&wr with an incrementing pattern -> count stays 16, full stays 1, data stays in order, no overflow, pointers wrap correctly.
- Threshold sweep: count 0..16 -> almost_empty=1 for count<=4, almost_full=1 for count>=12.
- FWFT=1: write 0x3C into empty -> next cycle dout=0x3C and empty=0 with no rd. rd -> next cycle empty=1, dout=0.
- Assert rst at count=7 mid-traffic -> next cycle count=0, empty=1, dout=0, flags cleared.
